if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, meaning PC value loaded on reset (bits [1:0] SHALL be 00).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 imem_req_valid  output  1  fetch request valid.
REQ-005 imem_req_ready  input  1  memory accepts request when high with imem_req_valid.
REQ-006 imem_addr  output  16  byte address of requested instruction.
REQ-007 imem_rsp_valid  input  1  response data valid; at most one per accepted request, at least 1 cycle after acceptance.
REQ-008 imem_rsp_data  input  32  fetched instruction word.
REQ-009 id_stall  input  1  decode cannot consume the IF/ID slot this cycle.
REQ-010 redirect  input  1  branch/jump taken; refetch from redirect_pc.
REQ-011 redirect_pc  input  16  new fetch address; bits [1:0] ignored, treated as 00.
REQ-012 id_valid  output  1  IF/ID slot holds a valid instruction.
REQ-013 id_instr  output  32  IF/ID instruction word.
REQ-014 id_pc  output  16  address of id_instr.
REQ-015 id_opcode  output  7  id_instr[6:0], feeds the control unit opcode input.

Function
REQ-016 FSM states SHALL be REQ, WAIT, HOLD; one outstanding request maximum.
REQ-017 REQ: imem_req_valid=1, imem_addr=pc; on valid&&ready capture req_pc=pc, go WAIT.
REQ-018 WAIT: imem_req_valid=0; on imem_rsp_valid with kill=0 and slot free, load slot (id_valid=1, id_instr=data, id_pc=req_pc), pc=req_pc+4, go REQ.
REQ-019 Slot free SHALL mean id_valid=0 or id_stall=0 in the same cycle.
REQ-020 WAIT, response arrives, kill=0, slot not free: store data/req_pc in hold buffer, pc=req_pc+4, go HOLD.
REQ-021 HOLD: imem_req_valid=0; when id_stall=0, move hold buffer into slot next edge, go REQ.
REQ-022 Slot consumed with no new instruction (id_valid=1, id_stall=0, no load) SHALL clear id_valid next cycle.
REQ-023 id_stall=1 with id_valid=1 SHALL hold id_valid, id_instr, id_pc unchanged.
REQ-024 redirect has top priority in all states: pc=redirect_pc&16'hFFFC, id_valid=0, hold buffer dropped next cycle.
REQ-025 redirect in REQ without handshake, or in HOLD: go REQ.
REQ-026 redirect in WAIT, or same cycle as REQ handshake: set kill=1, go/stay WAIT; killed response SHALL be discarded, kill cleared, go REQ.
REQ-027 redirect coincident with a non-killed response: response discarded, redirect wins.
REQ-028 PC arithmetic SHALL be modulo 2^16 (16'hFFFC+4 -> 16'h0000).
REQ-029 id_opcode SHALL be combinational from id_instr[6:0]; no extra latency.
REQ-030 Best-case throughput: one instruction per 2 cycles (REQ, WAIT with 1-cycle response).

Reset
REQ-031 With rst=1 at an edge: state=REQ, pc=RESET_PC, kill=0, id_valid=0, id_instr=0, id_pc=0, hold buffer empty.
REQ-032 id_opcode=7'b0000000 after reset, a non-writing opcode for the control unit.
REQ-033 imem_req_valid SHALL be 0 while rst=1; first request (addr=RESET_PC) in the first cycle after rst falls.
REQ-034 Reset mid-WAIT: a response arriving after reset SHALL be ignored (FSM in REQ, not WAIT).

Verification
REQ-035 Reset, ready=1, 1-cycle response 32'h002081B3 -> id_valid=1, id_pc=0, id_opcode=7'b0110011; next request addr=4.
REQ-036 id_stall=1 with id_valid=1, response 32'h00000013 arrives -> HOLD, slot unchanged; stall drops -> slot gets 0x00000013, next addr = id_pc+4.
REQ-037 redirect to 16'h0102 while in WAIT -> response discarded, id_valid=0, next imem_addr=16'h0100.
REQ-038 redirect in same cycle as request handshake -> that response dropped, next request addr=redirect_pc.
REQ-039 pc=16'hFFFC fetched -> following request addr=16'h0000.
REQ-040 imem_req_ready held 0 for 5 cycles -> imem_req_valid and imem_addr stable throughout, no slot change.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: issues one request at a time to instruction memory and
// fills the IF/ID slot, with a one-entry hold buffer for responses that arrive while decode is stalled.
module if_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [15:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        id_stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [15:0] id_pc,
    output logic [6:0]  id_opcode
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] req_pc_q, req_pc_d;
    logic        kill_q, kill_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [15:0] id_pc_q, id_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [15:0] hold_pc_q, hold_pc_d;

    logic handshake;
    logic slot_free;

    assign imem_req_valid = (state_q == S_REQ) && !rst;
    assign imem_addr      = pc_q;
    assign handshake      = imem_req_valid && imem_req_ready;
    assign slot_free      = !id_valid_q || !id_stall;

    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;
    assign id_opcode = id_instr_q[6:0];

    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        kill_d       = kill_q;
        // A consumed slot empties unless something below reloads it.
        id_valid_d   = id_valid_q && id_stall;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;

        unique case (state_q)
            S_REQ: begin
                if (handshake) begin
                    req_pc_d = pc_q;
                    state_d  = S_WAIT;
                    kill_d   = redirect;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                    kill_d  = 1'b0;
                    if (!kill_q && !redirect) begin
                        pc_d = req_pc_q + 16'd4;
                        if (slot_free) begin
                            id_valid_d = 1'b1;
                            id_instr_d = imem_rsp_data;
                            id_pc_d    = req_pc_q;
                        end else begin
                            hold_instr_d = imem_rsp_data;
                            hold_pc_d    = req_pc_q;
                            state_d      = S_HOLD;
                        end
                    end
                end else if (redirect) begin
                    // Response still outstanding: remember to drop it when it lands.
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    state_d = S_REQ;
                end else if (!id_stall) begin
                    id_valid_d = 1'b1;
                    id_instr_d = hold_instr_q;
                    id_pc_d    = hold_pc_q;
                    state_d    = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (redirect) begin
            pc_d       = redirect_pc & 16'hFFFC;
            id_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            req_pc_q     <= 16'h0000;
            kill_q       <= 1'b0;
            id_valid_q   <= 1'b0;
            id_instr_q   <= 32'h0000_0000;
            id_pc_q      <= 16'h0000;
            hold_instr_q <= 32'h0000_0000;
            hold_pc_q    <= 16'h0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            kill_q       <= kill_d;
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: the bench plays instruction memory and decode cycle by cycle
// and compares outputs 1 ns after each rising edge against hand-computed values.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [15:0] id_pc;
    logic [6:0]  id_opcode;

    int checks = 0;
    int errors = 0;

    if_stage #(.RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_stall       (id_stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_opcode      (id_opcode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-edge helpers that drop one-shot inputs after the edge.
    task automatic accept();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        step();
        imem_rsp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        id_stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

        // Reset state
        step(); step();
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_id_valid",  id_valid, 0);
        check("rst_id_instr",  id_instr, 0);
        check("rst_id_pc",     id_pc, 0);
        check("rst_opcode",    id_opcode, 0);
        rst = 1'b0;
        #1;
        check("first_req_valid", imem_req_valid, 1);
        check("first_req_addr",  imem_addr, 16'h0000);

        // Basic fetch with 1-cycle response
        accept();
        check("wait_no_req", imem_req_valid, 0);
        respond(32'h002081B3);
        check("fetch_valid",  id_valid, 1);
        check("fetch_pc",     id_pc, 16'h0000);
        check("fetch_opcode", id_opcode, 7'b0110011);
        check("fetch_next",   imem_addr, 16'h0004);
        check("fetch_reqv",   imem_req_valid, 1);

        // Response while decode stalls goes to the hold buffer
        id_stall = 1'b1;
        accept();
        respond(32'h00000013);
        check("hold_no_req", imem_req_valid, 0);
        check("hold_instr",  id_instr, 32'h002081B3);
        check("hold_pc",     id_pc, 16'h0000);
        step();
        check("hold2_instr", id_instr, 32'h002081B3);
        check("hold2_valid", id_valid, 1);
        id_stall = 1'b0;
        step();
        check("unhold_instr", id_instr, 32'h00000013);
        check("unhold_pc",    id_pc, 16'h0004);
        check("unhold_addr",  imem_addr, 16'h0008);
        check("unhold_reqv",  imem_req_valid, 1);

        // Slot consumed, then memory not ready for 5 cycles
        for (int i = 0; i < 5; i++) begin
            step();
            check("noready_reqv",  imem_req_valid, 1);
            check("noready_addr",  imem_addr, 16'h0008);
            check("noready_valid", id_valid, 0);
        end

        // Redirect while waiting: response discarded
        accept();
        redirect = 1'b1; redirect_pc = 16'h0102;
        step();
        redirect = 1'b0;
        check("rdw_valid", id_valid, 0);
        check("rdw_reqv",  imem_req_valid, 0);
        respond(32'h00000033);
        check("rdw_discard", id_valid, 0);
        check("rdw_reqv2",   imem_req_valid, 1);
        check("rdw_addr",    imem_addr, 16'h0100);

        // Redirect coincident with handshake
        redirect = 1'b1; redirect_pc = 16'h0200;
        accept();
        redirect = 1'b0;
        check("rdh_reqv", imem_req_valid, 0);
        respond(32'h00000033);
        check("rdh_discard", id_valid, 0);
        check("rdh_addr",    imem_addr, 16'h0200);

        // Redirect in REQ without handshake, then PC wrap
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        step();
        redirect = 1'b0;
        check("wrap_addr", imem_addr, 16'hFFFC);
        accept();
        respond(32'h00000063);
        check("wrap_pc",     id_pc, 16'hFFFC);
        check("wrap_opcode", id_opcode, 7'h63);
        check("wrap_next",   imem_addr, 16'h0000);

        // Redirect coincident with a live response
        accept();
        redirect = 1'b1; redirect_pc = 16'h0040;
        respond(32'h00000013);
        redirect = 1'b0;
        check("rdr_valid", id_valid, 0);
        check("rdr_addr",  imem_addr, 16'h0040);
        check("rdr_reqv",  imem_req_valid, 1);

        // Redirect while holding drops the hold buffer
        accept();
        respond(32'h00000013);
        check("rhd_fill_pc", id_pc, 16'h0040);
        id_stall = 1'b1;
        accept();
        respond(32'h00000093);
        check("rhd_in_hold", imem_req_valid, 0);
        redirect = 1'b1; redirect_pc = 16'h0080;
        step();
        redirect = 1'b0;
        check("rhd_valid", id_valid, 0);
        check("rhd_addr",  imem_addr, 16'h0080);
        id_stall = 1'b0;
        step();
        check("rhd_dropped", id_valid, 0);
        check("rhd_reqv",    imem_req_valid, 1);

        // Reset mid-WAIT: late response ignored
        accept();
        rst = 1'b1;
        step();
        check("rstw_reqv", imem_req_valid, 0);
        rst = 1'b0;
        #1;
        check("rstw_req", imem_req_valid, 1);
        respond(32'h00000013);
        check("rstw_ignored", id_valid, 0);
        check("rstw_addr",    imem_addr, 16'h0000);
        check("rstw_reqv2",   imem_req_valid, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
